cnn_mem_responder: RTL

- Synthesizable memory-side responder for the CONV accelerator interface.
- Serves the 4096-word image store on iaddr/idata and the five layer banks on the cwr/crd/csel port.
- Drives the ready/busy start handshake and reports completion and status.
- Replaces behavioural bench memories, so CONV runs against real RTL storage on FPGA and in gate-level simulation.

---
 rtl/cnn_mem_pkg.sv | 37 +++
 rtl/cnn_mem_bank.sv | 60 ++++++
 rtl/cnn_mem_responder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_mem_pkg : shared constants, csel encoding and FSM states for the     |
// |               CONV memory responder.                 Revision: 1.0       |
// +--------------------------------------------------------------------------+
package cnn_mem_pkg;

  localparam int DEF_DW        = 20;
  localparam int DEF_AW        = 12;
  localparam int DEF_IMG_DEPTH = 4096;
  localparam int DEF_L1_DEPTH  = 1024;
  localparam int DEF_L2_DEPTH  = 2048;

  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Layer index (0..2) recorded in wr_seen for a given bank select.
  function automatic logic [1:0] csel_seen_bit(input logic [2:0] sel);
    case (sel)
      CSEL_L0K0, CSEL_L0K1: return 2'd0;
      CSEL_L1K0, CSEL_L1K1: return 2'd1;
      default:              return 2'd2;
    endcase
  endfunction

endpackage : cnn_mem_pkg
`default_nettype wire

// File: rtl/cnn_mem_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_mem_bank : one-write / one-registered-read word store with address   |
// |                range flags. Option: CNN_MEM_WR_BYPASS_EN. Revision: 1.0  |
// +--------------------------------------------------------------------------+
module cnn_mem_bank #(
  parameter int DW    = 20,
  parameter int AW    = 12,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          waddr_ok,
  output logic          raddr_ok
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [IW-1:0] w_wa;
  logic [IW-1:0] w_ra;

  assign w_wa = waddr[IW-1:0];
  assign w_ra = raddr[IW-1:0];

  generate
    if (DEPTH >= (1 << AW)) begin : g_full_range
      assign waddr_ok = 1'b1;
      assign raddr_ok = 1'b1;
    end else begin : g_part_range
      assign waddr_ok = (waddr < AW'(DEPTH));
      assign raddr_ok = (raddr < AW'(DEPTH));
    end
  endgenerate

  // Storage is deliberately unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[w_wa] <= wdata;
    end
    if (re) begin
`ifdef CNN_MEM_WR_BYPASS_EN
      if (we && (w_wa == w_ra)) begin
        rdata <= wdata;
      end else begin
        rdata <= r_mem[w_ra];
      end
`else
      rdata <= r_mem[w_ra];
`endif
    end
  end

endmodule : cnn_mem_bank
`default_nettype wire

// File: rtl/cnn_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_mem_responder : image store, five layer banks and start handshake    |
// |   for CONV. Option: CNN_MEM_WR_BYPASS_EN (write-first). Revision: 1.0    |
// +--------------------------------------------------------------------------+
module cnn_mem_responder
  import cnn_mem_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int IMG_DEPTH = DEF_IMG_DEPTH,
  parameter int L1_DEPTH  = DEF_L1_DEPTH,
  parameter int L2_DEPTH  = DEF_L2_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic [2:0]    wr_seen,
  output logic          err,
  output logic          done
);

  state_t        r_state;
  state_t        w_next_state;
  logic          w_run;
  logic          w_enter_ready;

  logic          w_img_we;
  logic          w_img_re;
  logic          w_img_waddr_ok;
  logic          w_img_raddr_ok;
  logic [DW-1:0] w_img_rdata;
  logic          r_idata_vld;

  logic [7:0]    w_waddr_ok;
  logic [7:0]    w_raddr_ok;
  logic [DW-1:0] w_bank_rdata [8];
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic          w_wr_err;
  logic          w_rd_err;
  logic          r_rd_zero;
  logic [2:0]    r_rd_bank;
  logic [2:0]    r_wr_seen;
  logic          r_err;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_READY;
      ST_READY: if (busy)  w_next_state = ST_RUN;
      ST_RUN:   if (!busy) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign w_run         = (r_state == ST_RUN);
  assign w_enter_ready = (r_state == ST_IDLE) && start;
  assign ready         = (r_state == ST_READY);
  assign done          = (r_state == ST_DONE);

  // ---------------------------------------------------------- image store
  assign w_img_we = ld_en && (r_state == ST_IDLE) && w_img_waddr_ok;
  assign w_img_re = w_run && busy && w_img_raddr_ok;

  cnn_mem_bank #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (IMG_DEPTH)
  ) u_image (
    .clk      (clk),
    .we       (w_img_we),
    .waddr    (ld_addr),
    .wdata    (ld_data),
    .re       (w_img_re),
    .raddr    (iaddr),
    .rdata    (w_img_rdata),
    .waddr_ok (w_img_waddr_ok),
    .raddr_ok (w_img_raddr_ok)
  );

  // The qualifier is registered so idata reads zero on every non-read cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idata_vld <= 1'b0;
    end else begin
      r_idata_vld <= w_img_re;
    end
  end

  assign idata = r_idata_vld ? w_img_rdata : '0;

  // ---------------------------------------------------------- layer banks
  // Slots 0, 6 and 7 are unpopulated so an illegal csel reads as out-of-range.
  for (genvar k = 0; k < 8; k++) begin : g_bank
    if (k >= 1 && k <= 5) begin : g_real
      localparam int BANK_DEPTH = (k <= 2) ? IMG_DEPTH :
                                  (k <= 4) ? L1_DEPTH  : L2_DEPTH;
      cnn_mem_bank #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (BANK_DEPTH)
      ) u_bank (
        .clk      (clk),
        .we       (w_wr_ok && (csel == 3'(k))),
        .waddr    (caddr_wr),
        .wdata    (cdata_wr),
        .re       (w_rd_ok && (csel == 3'(k))),
        .raddr    (caddr_rd),
        .rdata    (w_bank_rdata[k]),
        .waddr_ok (w_waddr_ok[k]),
        .raddr_ok (w_raddr_ok[k])
      );
    end else begin : g_none
      assign w_waddr_ok[k]   = 1'b0;
      assign w_raddr_ok[k]   = 1'b0;
      assign w_bank_rdata[k] = '0;
    end
  end

  assign w_wr_ok  = cwr && w_run && w_waddr_ok[csel];
  assign w_rd_ok  = crd && w_run && w_raddr_ok[csel];
  assign w_wr_err = cwr && !w_wr_ok;
  assign w_rd_err = crd && !w_rd_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_seen <= 3'b000;
      r_err     <= 1'b0;
    end else if (w_enter_ready) begin
      r_wr_seen <= 3'b000;
      r_err     <= 1'b0;
    end else begin
      if (w_wr_err || w_rd_err) begin
        r_err <= 1'b1;
      end
      if (w_wr_ok) begin
        r_wr_seen <= r_wr_seen | (3'b001 << csel_seen_bit(csel));
      end
    end
  end

  // Read-side select is captured only on crd, so cdata_rd holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_zero <= 1'b1;
      r_rd_bank <= 3'b000;
    end else if (crd) begin
      r_rd_zero <= !w_rd_ok;
      r_rd_bank <= csel;
    end
  end

  assign cdata_rd = r_rd_zero ? '0 : w_bank_rdata[r_rd_bank];
  assign wr_seen  = r_wr_seen;
  assign err      = r_err;

endmodule : cnn_mem_responder
`default_nettype wire
